// File: rtl/link_pkg.sv
// Shared definitions for the four-phase link slave: FSM state encoding and
// default parameter values used by link_slave_fifo and link_fifo.
package link_pkg;

  // Handshake FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } link_state_e;

  // Default configuration
  localparam int LINK_DATA_W     = 8;
  localparam int LINK_DEPTH      = 4;
  localparam int LINK_ACK_CYCLES = 2;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int link_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Receive FIFO for the link slave. Power-of-two depth, pointers wrap
// naturally. The head word is read combinationally so it is presented in the
// same cycle the FIFO becomes non-empty. Full/empty are derived from the
// registered occupancy, so a push into a full FIFO is refused even when a pop
// happens on the same edge.
module link_fifo
  import link_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W,
  parameter int DEPTH  = LINK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = link_count_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Requests against a full/empty FIFO are silently dropped
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/link_slave_fifo.sv
// Four-phase req/ack link slave feeding a receive FIFO.
// A request seen in IDLE with room in the FIFO pushes data_in, then ack is
// held for ACK_CYCLES cycles, then the FSM waits for req to drop before the
// next transfer can start. A full FIFO back-pressures by withholding ack.
// Optional feature: define LINK_SLAVE_PARITY_EN to add the data_par input
// (even parity over data_in) and the sticky par_err output; words with bad
// parity are still acknowledged but not stored.
module link_slave_fifo
  import link_pkg::*;
#(
  parameter int DATA_W     = LINK_DATA_W,
  parameter int DEPTH      = LINK_DEPTH,
  parameter int ACK_CYCLES = LINK_ACK_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   ack,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef LINK_SLAVE_PARITY_EN
  input  logic                   data_par,
  output logic                   par_err,
`endif
  output logic [DATA_W-1:0]      out_data,
  output logic [DATA_W-1:0]      last_byte,
  output logic [$clog2(DEPTH):0] fifo_count
);

  // Ack counter only has to reach ACK_CYCLES-1
  localparam int ACNT_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

  link_state_e       state_q, state_d;
  logic [ACNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic              ack_q;
  logic [DATA_W-1:0] last_byte_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              accept;
  logic              word_ok;

  // A transfer starts only from IDLE and only when the FIFO has room
  assign accept = (state_q == IDLE) && req && !fifo_full;

`ifdef LINK_SLAVE_PARITY_EN
  logic par_err_q;

  // Even parity: data_par must equal the XOR of all data bits
  assign word_ok = ((^data_in) == data_par);
  assign par_err = par_err_q;

  // Sticky parity error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (accept && !word_ok) begin
      par_err_q <= 1'b1;
    end
  end
`else
  assign word_ok = 1'b1;
`endif

  assign fifo_push = accept && word_ok;

  link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (data_in),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign ack       = ack_q;
  assign last_byte = last_byte_q;

  // Handshake next-state logic and ack duration counter
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ACK;
          ack_cnt_d = '0;
        end
      end
      ACK: begin
        if (ack_cnt_q == ACNT_W'(ACK_CYCLES - 1)) begin
          state_d   = WAIT_LOW;
          ack_cnt_d = '0;
        end else begin
          ack_cnt_d = ack_cnt_q + ACNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        ack_cnt_d = '0;
      end
    endcase
  end

  // State, counter and registered ack (ack mirrors the ACK state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_cnt_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      ack_q     <= (state_d == ACK);
    end
  end

  // Capture the most recently stored word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_byte_q <= '0;
    end else if (fifo_push) begin
      last_byte_q <= data_in;
    end
  end

endmodule

// File: tb/tb_link_slave_fifo.sv
// Self-checking bench for link_slave_fifo: directed transfers drive the link,
// expected FIFO words go into a scoreboard queue, and a monitor compares
// every word the consumer takes against the queue head.
module tb_link_slave_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] data_in;
  logic       ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] last_byte;
  logic [2:0] fifo_count;

  // Second instance with a longer ack
  logic       req3;
  logic [7:0] data3;
  logic       ack3;
  logic       out_valid3;
  logic       out_ready3;
  logic [7:0] out_data3;
  logic [7:0] last_byte3;
  logic [2:0] fifo_count3;

`ifdef LINK_SLAVE_PARITY_EN
  logic data_par;
  logic par_err;
  logic data_par3;
  logic par_err3;
`endif

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  always #5 clk = ~clk;

  link_slave_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef LINK_SLAVE_PARITY_EN
    .data_par   (data_par),
    .par_err    (par_err),
`endif
    .out_data   (out_data),
    .last_byte  (last_byte),
    .fifo_count (fifo_count)
  );

  link_slave_fifo #(.ACK_CYCLES(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req3),
    .data_in    (data3),
    .ack        (ack3),
    .out_valid  (out_valid3),
    .out_ready  (out_ready3),
`ifdef LINK_SLAVE_PARITY_EN
    .data_par   (data_par3),
    .par_err    (par_err3),
`endif
    .out_data   (out_data3),
    .last_byte  (last_byte3),
    .fifo_count (fifo_count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted head word must match the oldest expected
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got 0x%0h, required no word", out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (out_data !== exp_word) begin
          fails++;
          $display("FAIL pop_data: got 0x%0h, required 0x%0h", out_data, exp_word);
        end else begin
          $display("[TB] pop 0x%0h", out_data);
        end
      end
    end
  end

  // One complete four-phase transfer; optionally pop on the request edge
  task automatic xfer(input logic [7:0] d, input bit pop, input bit bad_par,
                      output int waited, output int len);
    data_in   = d;
    req       = 1'b1;
    out_ready = pop;
`ifdef LINK_SLAVE_PARITY_EN
    data_par  = (^d) ^ bad_par;
`endif
    if (!bad_par) exp_q.push_back(d);
    tick();
    out_ready = 1'b0;
    waited    = 1;
    while (!ack && waited < 40) begin
      tick();
      waited++;
    end
    if (!ack) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, required ack", waited);
    end
    len = 0;
    while (ack && len < 40) begin
      len++;
      tick();
    end
    req = 1'b0;
    tick();
    $display("[TB] xfer 0x%0h wait=%0d ack_len=%0d count=%0d", d, waited, len, fifo_count);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int l;
    rst_n      = 1'b0;
    req        = 1'b0;
    data_in    = 8'h00;
    out_ready  = 1'b0;
    req3       = 1'b0;
    data3      = 8'h00;
    out_ready3 = 1'b0;
`ifdef LINK_SLAVE_PARITY_EN
    data_par   = 1'b0;
    data_par3  = 1'b0;
`endif
    #3;
    check("reset_ack", ack, 0);
    check("reset_valid", out_valid, 0);
    check("reset_count", fifo_count, 0);
    check("reset_last", last_byte, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single transfer
    xfer(8'hA5, 1'b0, 1'b0, w, l);
    check("single_latency", w, 1);
    check("single_ack_len", l, 2);
    check("single_out_data", out_data, 8'hA5);
    check("single_valid", out_valid, 1);
    check("single_last", last_byte, 8'hA5);
    check("single_count", fifo_count, 1);
    drain(1);
    check("drain_count", fifo_count, 0);
    check("drain_valid", out_valid, 0);
    drain(1);
    check("empty_pop_ignored", fifo_count, 0);

    // Fill, then back-pressure on the fifth word
    for (int i = 1; i <= 4; i++) xfer(8'(i), 1'b0, 1'b0, w, l);
    check("fill_count", fifo_count, 4);
    data_in = 8'h05;
    req     = 1'b1;
`ifdef LINK_SLAVE_PARITY_EN
    data_par = ^data_in;
`endif
    exp_q.push_back(8'h05);
    tick();
    check("full_no_ack", ack, 0);
    check("full_count", fifo_count, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pop_no_ack", ack, 0);
    check("full_pop_count", fifo_count, 3);
    tick();
    check("freed_ack", ack, 1);
    check("freed_count", fifo_count, 4);
    check("freed_last", last_byte, 8'h05);
    l = 0;
    while (ack && l < 40) begin
      l++;
      tick();
    end
    check("freed_ack_len", l, 2);
    req = 1'b0;
    tick();
    drain(4);
    check("fill_drained", fifo_count, 0);

    // Simultaneous push and pop across the pointer wrap
    xfer(8'h10, 1'b0, 1'b0, w, l);
    xfer(8'h11, 1'b0, 1'b0, w, l);
    check("pp_pre_count", fifo_count, 2);
    xfer(8'h12, 1'b1, 1'b0, w, l);
    check("pp_count_a", fifo_count, 2);
    xfer(8'h13, 1'b1, 1'b0, w, l);
    check("pp_count_b", fifo_count, 2);
    drain(2);
    check("pp_drained", fifo_count, 0);

    // req held high after ack: no second push
    data_in = 8'h20;
    req     = 1'b1;
`ifdef LINK_SLAVE_PARITY_EN
    data_par = ^data_in;
`endif
    exp_q.push_back(8'h20);
    tick();
    check("hold_ack", ack, 1);
    l = 0;
    while (ack && l < 40) begin
      l++;
      tick();
    end
    repeat (4) begin
      tick();
      check("hold_no_ack", ack, 0);
    end
    check("hold_count", fifo_count, 1);
    req = 1'b0;
    tick();
    xfer(8'h21, 1'b0, 1'b0, w, l);
    check("hold_next_count", fifo_count, 2);
    drain(2);

    // Three-cycle ack build
    data3 = 8'h77;
`ifdef LINK_SLAVE_PARITY_EN
    data_par3 = ^data3;
`endif
    req3 = 1'b1;
    tick();
    l = 0;
    while (ack3 && l < 40) begin
      l++;
      tick();
    end
    check("ack3_len", l, 3);
    req3 = 1'b0;
    tick();
    check("ack3_count", fifo_count3, 1);
    check("ack3_data", out_data3, 8'h77);
    check("ack3_last", last_byte3, 8'h77);
    check("ack3_valid", out_valid3, 1);
    $display("[TB] ack3 transfer 0x77 ack_len=%0d", l);

    // Reset during ACK
    data_in = 8'h30;
    req     = 1'b1;
`ifdef LINK_SLAVE_PARITY_EN
    data_par = ^data_in;
`endif
    tick();
    check("rst_pre_ack", ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ack", ack, 0);
    check("rst_count", fifo_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", last_byte, 0);
    exp_q.delete();
    data_in = 8'h31;
`ifdef LINK_SLAVE_PARITY_EN
    data_par = ^data_in;
`endif
    tick();
    rst_n = 1'b1;
    exp_q.push_back(8'h31);
    tick();
    check("rst_new_ack", ack, 1);
    check("rst_new_count", fifo_count, 1);
    check("rst_new_last", last_byte, 8'h31);
    l = 0;
    while (ack && l < 40) begin
      l++;
      tick();
    end
    repeat (3) tick();
    check("rst_single_push", fifo_count, 1);
    req = 1'b0;
    tick();
    drain(1);
    check("rst_drained", fifo_count, 0);

`ifdef LINK_SLAVE_PARITY_EN
    // Parity error: acknowledged, not stored, sticky flag
    check("par_clean", par_err, 0);
    xfer(8'h03, 1'b0, 1'b1, w, l);
    check("par_ack_len", l, 2);
    check("par_count", fifo_count, 0);
    check("par_err_set", par_err, 1);
    check("par_last_kept", last_byte, 8'h31);
    xfer(8'h03, 1'b0, 1'b0, w, l);
    check("par_good_count", fifo_count, 1);
    check("par_err_sticky", par_err, 1);
    check("par3_clean", par_err3, 0);
    drain(1);
    rst_n = 1'b0;
    #1;
    check("par_err_reset", par_err, 0);
    rst_n = 1'b1;
    tick();
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
